// File: rtl/uart_rx_top_if.sv
// Signal bundle between the RX front end (pad side / configuration) and the
// uart_rx_top receiver. master drives the line and configuration, slave is
// the receiver that returns the byte and the error strobes.
interface uart_rx_top_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_ext_err;
    logic                  stop_ext_err;
    logic                  start_ext_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, prescale,
        input  P_DATA, data_valid, parity_ext_err, stop_ext_err, start_ext_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, prescale,
        output P_DATA, data_valid, parity_ext_err, stop_ext_err, start_ext_err
    );
endinterface

// File: rtl/uart_rx_top.sv
// UART receiver with oversampling: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. Emits the byte with a one-cycle
// data_valid strobe and one-cycle start/parity/stop error pulses.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: when defined each bit is the
// majority of three samples around mid-bit; otherwise a single mid-bit sample.
module uart_rx_top #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_top_if.slave  bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic [PRESCALE_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic                  par_fail_reg, par_fail_next;
    logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
    logic                  valid_reg, valid_next;
    logic                  perr_reg, perr_next;
    logic                  serr_reg, serr_next;
    logic                  sterr_reg, sterr_next;

    // Configuration frozen for the duration of a frame
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  sampled_bit;
    logic                  start_det;
    logic                  bit_end;
    logic [PRESCALE_W-1:0] half_point;
    logic                  exp_parity;

    assign start_det  = (state_reg == ST_IDLE) && !bus.RX_IN;
    assign bit_end    = (edge_cnt_reg == prescale_reg - PRESCALE_W'(1));
    assign half_point = prescale_reg >> 1;
    assign exp_parity = (^shift_reg) ^ par_typ_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [2:0] samples_reg;

    // Capture the three samples at mid-bit-1, mid-bit and mid-bit+1
    for (genvar gi = 0; gi < 3; gi++) begin : g_sample
        always_ff @(posedge CLK) begin
            if (RST)
                samples_reg[gi] <= 1'b0;
            else if (state_reg != ST_IDLE &&
                     edge_cnt_reg == half_point - PRESCALE_W'(1) + PRESCALE_W'(gi))
                samples_reg[gi] <= bus.RX_IN;
        end
    end

    assign sampled_bit = (samples_reg[0] & samples_reg[1]) |
                         (samples_reg[0] & samples_reg[2]) |
                         (samples_reg[1] & samples_reg[2]);
`else
    logic sample_reg;

    // Single capture exactly at mid-bit
    always_ff @(posedge CLK) begin
        if (RST)
            sample_reg <= 1'b0;
        else if (state_reg != ST_IDLE && edge_cnt_reg == half_point)
            sample_reg <= bus.RX_IN;
    end

    assign sampled_bit = sample_reg;
`endif

    // Latch prescale and parity settings on the falling start edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_reg <= '0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
        end else if (start_det) begin
            prescale_reg <= bus.prescale;
            par_en_reg   <= bus.PAR_EN;
            par_typ_reg  <= bus.PAR_TYP;
        end
    end

    // Each data bit lands in its own slot at the end of its bit period
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
        always_ff @(posedge CLK) begin
            if (RST)
                shift_reg[gi] <= 1'b0;
            else if (state_reg == ST_DATA && bit_end && bit_cnt_reg == BIT_W'(gi))
                shift_reg[gi] <= sampled_bit;
        end
    end

    // Frame sequencing, counters and one-cycle output strobes
    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = edge_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        par_fail_next = par_fail_reg;
        p_data_next   = p_data_reg;
        valid_next    = 1'b0;
        perr_next     = 1'b0;
        serr_next     = 1'b0;
        sterr_next    = 1'b0;

        if (state_reg != ST_IDLE)
            edge_cnt_next = bit_end ? '0 : edge_cnt_reg + PRESCALE_W'(1);

        case (state_reg)
            ST_IDLE: begin
                if (!bus.RX_IN) begin
                    state_next    = ST_START;
                    edge_cnt_next = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    if (sampled_bit) begin
                        sterr_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = par_en_reg ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != exp_parity) begin
                        perr_next     = 1'b1;
                        par_fail_next = 1'b1;
                    end
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        serr_next = 1'b1;
                    end else if (!par_fail_reg) begin
                        p_data_next = shift_reg;
                        valid_next  = 1'b1;
                    end
                    par_fail_next = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight silently
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            par_fail_reg <= 1'b0;
            p_data_reg   <= '0;
            valid_reg    <= 1'b0;
            perr_reg     <= 1'b0;
            serr_reg     <= 1'b0;
            sterr_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_fail_reg <= par_fail_next;
            p_data_reg   <= p_data_next;
            valid_reg    <= valid_next;
            perr_reg     <= perr_next;
            serr_reg     <= serr_next;
            sterr_reg    <= sterr_next;
        end
    end

    assign bus.P_DATA         = p_data_reg;
    assign bus.data_valid     = valid_reg;
    assign bus.parity_ext_err = perr_reg;
    assign bus.stop_ext_err   = serr_reg;
    assign bus.start_ext_err  = sterr_reg;
endmodule

// File: tb/tb_uart_rx_top.sv
// Directed testbench for uart_rx_top: drives serial frames at negedge,
// counts output pulses at negedge and checks per-frame deltas and latency.
module tb_uart_rx_top;
    logic CLK = 1'b0;
    logic RST;

    uart_rx_top_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_top #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int n_valid = 0, n_perr = 0, n_serr = 0, n_sterr = 0;
    int last_valid_cyc = 0;
    int s_valid, s_perr, s_serr, s_sterr;
    int start_cyc;
    int checks = 0;
    int failures = 0;

    always @(posedge CLK) cyc++;

    // Pulse counters sampled away from the active edge
    always @(negedge CLK) begin
        if (bus.data_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (bus.parity_ext_err) n_perr++;
        if (bus.stop_ext_err)   n_serr++;
        if (bus.start_ext_err)  n_sterr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = n_valid;
        s_perr  = n_perr;
        s_serr  = n_serr;
        s_sterr = n_sterr;
    endtask

    // Compare pulse-count deltas since the last snapshot and the held byte
    task automatic check_frame(input string tag, input int ev, input int ep, input int es,
                               input int est, input logic [7:0] pdata);
        check({tag, "_valid"}, 32'(n_valid - s_valid), 32'(ev));
        check({tag, "_perr"},  32'(n_perr - s_perr),   32'(ep));
        check({tag, "_serr"},  32'(n_serr - s_serr),   32'(es));
        check({tag, "_sterr"}, 32'(n_sterr - s_sterr), 32'(est));
        check({tag, "_pdata"}, 32'(bus.P_DATA),        32'(pdata));
    endtask

    task automatic drive_bit(input logic b, input int ps);
        bus.RX_IN = b;
        repeat (ps) @(negedge CLK);
    endtask

    // Full frame starting on a negedge; optionally disturbs config mid-frame
    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_bit, input int ps, input logic poke);
        logic       saved_en;
        logic [5:0] saved_ps;
        snap();
        start_cyc = cyc;
        drive_bit(1'b0, ps);
        saved_en = bus.PAR_EN;
        saved_ps = bus.prescale;
        if (poke) begin
            bus.PAR_EN   = ~bus.PAR_EN;
            bus.prescale = 6'd16;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
        if (has_par) drive_bit(par_bit, ps);
        drive_bit(stop_bit, ps);
        drive_bit(1'b1, 2 * ps);
        bus.PAR_EN   = saved_en;
        bus.prescale = saved_ps;
    endtask

    initial begin
        RST          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b0;
        bus.prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check("rst_pdata", 32'(bus.P_DATA), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_errs", {29'd0, bus.parity_ext_err, bus.stop_ext_err, bus.start_ext_err}, 32'h0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Even parity, 0x95, parity bit 0
        send_frame(8'h95, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        check_frame("even_95", 1, 0, 0, 0, 8'h95);
        check("even_95_lat", 32'(last_valid_cyc - start_cyc), 32'd89);

        // Even parity, 0xFF
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        check_frame("even_ff", 1, 0, 0, 0, 8'hFF);

        // Parity disabled
        bus.PAR_EN = 1'b0;
        send_frame(8'h95, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        check_frame("nopar_95", 1, 0, 0, 0, 8'h95);
        check("nopar_95_lat", 32'(last_valid_cyc - start_cyc), 32'd81);

        // Odd parity with a 0 parity bit on 0x95: mismatch
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b1;
        send_frame(8'h95, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        check_frame("par_err", 0, 1, 0, 0, 8'h95);

        // Framing error: correct even parity, stop bit 0
        bus.PAR_TYP = 1'b0;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 8, 1'b0);
        check_frame("stop_err", 0, 0, 1, 0, 8'h95);

        // Start glitch: line low for two clocks only
        snap();
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (24) @(negedge CLK);
        check_frame("glitch", 0, 0, 0, 1, 8'h95);

        // Good frame right after the glitch
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        check_frame("after_glitch", 1, 0, 0, 0, 8'h3C);

        // Prescale 16, parity off
        bus.PAR_EN   = 1'b0;
        bus.prescale = 6'd16;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        check_frame("ps16_a5", 1, 0, 0, 0, 8'hA5);
        check("ps16_a5_lat", 32'(last_valid_cyc - start_cyc), 32'd161);

        // Config changed mid-frame must not affect the frame in flight
        bus.PAR_EN   = 1'b1;
        bus.prescale = 6'd8;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 8, 1'b1);
        check_frame("cfg_latch", 1, 0, 0, 0, 8'hC3);

        // Reset mid-frame: silent abort, P_DATA cleared
        snap();
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        RST       = 1'b1;
        bus.RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (120) @(negedge CLK);
        check_frame("mid_rst", 0, 0, 0, 0, 8'h00);

        // Recovery after reset
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 8, 1'b0);
        check_frame("post_rst", 1, 0, 0, 0, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
